// File: rtl/rename_recovery_ctrl.sv
// rename_recovery_ctrl: sequences drain, sRAT copy and free-list restore after a flush
module rename_recovery_ctrl #(
  parameter int PREG_INDEX_WIDTH = 7,
  parameter int PRF_NUM = 128,
  parameter int COPY_LANES = 8,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_req,
  input  logic flush_is_exception,
  input  logic retire_busy,
  input  logic [32*PREG_INDEX_WIDTH-1:0] arat_map_flat,
  input  logic [PREG_INDEX_WIDTH-1:0] arat_fl_head,
  input  logic [PREG_INDEX_WIDTH-1:0] arat_fl_tail,
  output logic retire_block,
  output logic rename_stall,
  output logic srat_wr_en,
  output logic [4:0] srat_wr_base,
  output logic [COPY_LANES*PREG_INDEX_WIDTH-1:0] srat_wr_data,
  output logic fl_restore_valid,
  output logic [PREG_INDEX_WIDTH-1:0] fl_restore_head,
  output logic [PREG_INDEX_WIDTH-1:0] fl_restore_tail,
  output logic recover_done,
  output logic recover_cause,
  output logic busy,
  output logic drain_timeout_err,
  output logic [7:0] flush_merge_cnt
);
  localparam int W = PREG_INDEX_WIDTH;
  localparam int DW = DRAIN_TIMEOUT > 2 ? $clog2(DRAIN_TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, DRAIN, COPY, FL_RESTORE, DONE} state_t;
  if (PRF_NUM > (1 << PREG_INDEX_WIDTH)) begin : g_bad_prf
    $error("PRF_NUM does not fit in PREG_INDEX_WIDTH");
  end
  state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic cause_q, cause_d;
  logic drain_expire;
  logic [4:0] base_d;
  logic [W-1:0] amap [32];
  logic [COPY_LANES*W-1:0] data_w;
  for (genvar i = 0; i < 32; i++) begin : g_amap
    assign amap[i] = arat_map_flat[i*W +: W];
  end
  for (genvar j = 0; j < COPY_LANES; j++) begin : g_lane
    assign data_w[j*W +: W] = amap[base_d + 5'(j)];
  end
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cause_d = cause_q;
    drain_expire = state_q == DRAIN && retire_busy && drain_q == DW'(DRAIN_TIMEOUT-1);
    case (state_q)
      IDLE: begin
        drain_d = '0;
        if (flush_req) begin
          state_d = DRAIN;
          cause_d = flush_is_exception;
        end
      end
      DRAIN: begin
        drain_d = retire_busy ? drain_q + 1'b1 : drain_q;
        state_d = (!retire_busy || drain_expire) ? COPY : DRAIN;
      end
      COPY: state_d = srat_wr_base == 5'(32-COPY_LANES) ? FL_RESTORE : COPY;
      FL_RESTORE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    // a flush while busy only sharpens the cause; the frozen aRAT is still valid
    if (state_q != IDLE && flush_req) cause_d = cause_q | flush_is_exception;
    base_d = (state_d == COPY && state_q == COPY) ? srat_wr_base + 5'(COPY_LANES) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= '0;
      cause_q <= 1'b0;
      retire_block <= 1'b0;
      rename_stall <= 1'b0;
      busy <= 1'b0;
      srat_wr_en <= 1'b0;
      srat_wr_base <= '0;
      srat_wr_data <= '0;
      fl_restore_valid <= 1'b0;
      fl_restore_head <= '0;
      fl_restore_tail <= '0;
      recover_done <= 1'b0;
      recover_cause <= 1'b0;
      drain_timeout_err <= 1'b0;
      flush_merge_cnt <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cause_q <= cause_d;
      retire_block <= state_d != IDLE;
      rename_stall <= state_d != IDLE;
      busy <= state_d != IDLE;
      srat_wr_en <= state_d == COPY;
      srat_wr_base <= base_d;
      srat_wr_data <= state_d == COPY ? data_w : '0;
      fl_restore_valid <= state_d == FL_RESTORE;
      fl_restore_head <= state_d == FL_RESTORE ? arat_fl_head : '0;
      fl_restore_tail <= state_d == FL_RESTORE ? arat_fl_tail : '0;
      recover_done <= state_d == DONE;
      recover_cause <= state_d == DONE && cause_d;
      if (drain_expire) drain_timeout_err <= 1'b1;
      if (state_q != IDLE && flush_req && flush_merge_cnt != 8'hff) flush_merge_cnt <= flush_merge_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// tb_rename_recovery_ctrl: directed checks of recovery sequencing, merging, timeout and reset
module tb_rename_recovery_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_req = 1'b0;
  logic flush_is_exception = 1'b0;
  logic retire_busy = 1'b0;
  logic [223:0] arat_map_flat = '0;
  logic [6:0] arat_fl_head = '0;
  logic [6:0] arat_fl_tail = '0;
  logic retire_block, rename_stall, srat_wr_en, fl_restore_valid, recover_done, recover_cause, busy, drain_timeout_err;
  logic [4:0] srat_wr_base;
  logic [55:0] srat_wr_data;
  logic [6:0] fl_restore_head, fl_restore_tail;
  logic [7:0] flush_merge_cnt;
  logic [6:0] amap [32];
  int n_checks = 0;
  int n_fail = 0;

  rename_recovery_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .flush_is_exception(flush_is_exception),
    .retire_busy(retire_busy), .arat_map_flat(arat_map_flat), .arat_fl_head(arat_fl_head),
    .arat_fl_tail(arat_fl_tail), .retire_block(retire_block), .rename_stall(rename_stall),
    .srat_wr_en(srat_wr_en), .srat_wr_base(srat_wr_base), .srat_wr_data(srat_wr_data),
    .fl_restore_valid(fl_restore_valid), .fl_restore_head(fl_restore_head),
    .fl_restore_tail(fl_restore_tail), .recover_done(recover_done), .recover_cause(recover_cause),
    .busy(busy), .drain_timeout_err(drain_timeout_err), .flush_merge_cnt(flush_merge_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_arat(input int off, input int head, input int tail);
    for (int i = 0; i < 32; i++) begin
      amap[i] = 7'(i + off);
      arat_map_flat[i*7 +: 7] = amap[i];
    end
    arat_fl_head = 7'(head);
    arat_fl_tail = 7'(tail);
  endtask

  task automatic start(input bit exc);
    flush_req = 1'b1;
    flush_is_exception = exc;
    tick;
    flush_req = 1'b0;
    flush_is_exception = 1'b0;
  endtask

  // walks cycles 1..IDLE after a flush; fa/fb are cycles carrying an extra exception flush
  task automatic recover(input int nbusy, input int fa, input int fb, input bit cause_exp, input bit err_exp);
    int nd;
    int g;
    logic [55:0] ed;
    nd = nbusy >= 16 ? 16 : nbusy + 1;
    for (int c = 1; c <= nd + 7; c++) begin
      retire_busy = c <= nbusy && c <= nd;
      flush_req = c == fa || c == fb;
      flush_is_exception = flush_req;
      g = c - nd - 1;
      ed = '0;
      if (g >= 0 && g < 4) for (int j = 0; j < 8; j++) ed[j*7 +: 7] = amap[g*8 + j];
      check("rename_stall", rename_stall, c <= nd + 6);
      check("retire_block", retire_block, c <= nd + 6);
      check("busy", busy, c <= nd + 6);
      check("srat_wr_en", srat_wr_en, g >= 0 && g < 4);
      check("srat_wr_data", srat_wr_data, ed);
      if (g >= 0 && g < 4) check("srat_wr_base", srat_wr_base, g * 8);
      check("fl_restore_valid", fl_restore_valid, c == nd + 5);
      if (c == nd + 5) begin
        check("fl_restore_head", fl_restore_head, arat_fl_head);
        check("fl_restore_tail", fl_restore_tail, arat_fl_tail);
      end
      check("recover_done", recover_done, c == nd + 6);
      if (c == nd + 6) check("recover_cause", recover_cause, cause_exp);
      if (c > nd) check("drain_timeout_err", drain_timeout_err, err_exp);
      if (c < nd + 7) tick;
    end
    flush_req = 1'b0;
    flush_is_exception = 1'b0;
    retire_busy = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_stall", rename_stall, 0);
    check("rst_retire_block", retire_block, 0);
    check("rst_wr_en", srat_wr_en, 0);
    check("rst_wr_data", srat_wr_data, 0);
    check("rst_done", recover_done, 0);
    check("rst_merge", flush_merge_cnt, 0);
    check("rst_err", drain_timeout_err, 0);
    #13 rst_n = 1'b1;
    tick;
    set_arat(40, 5, 100);
    start(1'b0);
    recover(0, 0, 0, 1'b0, 1'b0);
    check("basic_merge", flush_merge_cnt, 0);
    set_arat(90, 17, 63);
    start(1'b0);
    recover(3, 0, 0, 1'b0, 1'b0);
    check("drain_wait_err", drain_timeout_err, 0);
    set_arat(3, 120, 2);
    start(1'b0);
    recover(0, 3, 7, 1'b1, 1'b0);
    check("merged_cnt", flush_merge_cnt, 2);
    start(1'b1);
    recover(0, 0, 0, 1'b1, 1'b0);
    check("merged_cnt_after", flush_merge_cnt, 2);
    set_arat(60, 9, 77);
    start(1'b0);
    recover(100, 0, 0, 1'b0, 1'b1);
    repeat (3) tick;
    check("timeout_sticky", drain_timeout_err, 1);
    check("timeout_idle", busy, 0);
    set_arat(40, 5, 100);
    start(1'b0);
    tick;
    tick;
    check("pre_rst_wr_en", srat_wr_en, 1);
    check("pre_rst_base", srat_wr_base, 8);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_stall", rename_stall, 0);
    check("midrst_retire_block", retire_block, 0);
    check("midrst_wr_en", srat_wr_en, 0);
    check("midrst_wr_base", srat_wr_base, 0);
    check("midrst_wr_data", srat_wr_data, 0);
    check("midrst_err", drain_timeout_err, 0);
    check("midrst_merge", flush_merge_cnt, 0);
    #1 rst_n = 1'b1;
    tick;
    check("post_rst_busy", busy, 0);
    start(1'b0);
    recover(0, 0, 0, 1'b0, 1'b0);
    flush_req = 1'b1;
    repeat (16) tick;
    check("sat_partial", flush_merge_cnt, 14);
    repeat (400) tick;
    check("sat_full", flush_merge_cnt, 255);
    flush_req = 1'b0;
    repeat (10) tick;
    check("sat_idle", busy, 0);
    check("sat_hold", flush_merge_cnt, 255);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
